// File: rtl/pmbist_seq_ctrl.sv
// pmbist_seq_ctrl: runs a stored program of BIST instruction words on the engine.
// Ports: load/clear/run/abort from tester, eng_* handshake, pass/fail status out.
module pmbist_seq_ctrl #(
  parameter int IW      = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_valid,
  input  logic [IW-1:0]              load_data,
  output logic                       load_ready,
  input  logic                       clear,
  input  logic                       run,
  input  logic                       abort,
  input  logic                       stop_on_fail,
  output logic [IW-1:0]              eng_instr,
  output logic                       eng_start,
  input  logic                       eng_done,
  input  logic                       eng_fail,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic                       fail_valid,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] prog [DEPTH];
  logic          prog_we;

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] eng_instr_q, eng_instr_d;
  logic          pass_q, pass_d;
  logic          fail_valid_q, fail_valid_d;
  logic [AW-1:0] fail_idx_q, fail_idx_d;
  logic          timeout_err_q, timeout_err_d;
  logic          sof_q, sof_d;

  logic last_el;
  logic end_run;
  logic tmo;

  assign last_el = (CW'(idx_q) == count_q - CW'(1));
  assign end_run = (eng_fail && sof_q) || last_el;
  // timer counts cycles since eng_start, so it reads 1 in the first WAIT cycle
  assign tmo     = (timer_q == TW'(TIMEOUT - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!clear && run)
          state_d = (count_q == '0) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        state_d = abort ? S_FINISH : S_WAIT;
      end
      S_WAIT: begin
        if (abort)         state_d = S_FINISH;
        else if (eng_done) state_d = end_run ? S_FINISH : S_ISSUE;
        else if (tmo)      state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    load_ready = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
    eng_start  = (state_q == S_ISSUE);
    busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    done       = (state_q == S_FINISH);
  end

  // datapath next values
  always_comb begin
    count_d       = count_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    eng_instr_d   = eng_instr_q;
    pass_d        = pass_q;
    fail_valid_d  = fail_valid_q;
    fail_idx_d    = fail_idx_q;
    timeout_err_d = timeout_err_q;
    sof_d         = sof_q;
    prog_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (run) begin
          idx_d         = '0;
          pass_d        = 1'b1;
          fail_valid_d  = 1'b0;
          timeout_err_d = 1'b0;
          sof_d         = stop_on_fail;
        end else if (load_valid && load_ready) begin
          prog_we = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      S_ISSUE: begin
        timer_d = TW'(1);
        if (abort) pass_d = 1'b0;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (abort) begin
          // a same-cycle engine result is discarded
          pass_d = 1'b0;
        end else if (eng_done) begin
          if (eng_fail) begin
            pass_d = 1'b0;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_idx_d   = idx_q;
            end
          end
          if (!end_run) idx_d = idx_q + AW'(1);
        end else if (tmo) begin
          timeout_err_d = 1'b1;
          pass_d        = 1'b0;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_idx_d   = idx_q;
          end
        end
      end
      default: ;
    endcase
    if (state_d == S_ISSUE) begin
      eng_instr_d = prog[idx_d];
      timer_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      eng_instr_q   <= '0;
      pass_q        <= 1'b0;
      fail_valid_q  <= 1'b0;
      fail_idx_q    <= '0;
      timeout_err_q <= 1'b0;
      sof_q         <= 1'b0;
    end else begin
      count_q       <= count_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      eng_instr_q   <= eng_instr_d;
      pass_q        <= pass_d;
      fail_valid_q  <= fail_valid_d;
      fail_idx_q    <= fail_idx_d;
      timeout_err_q <= timeout_err_d;
      sof_q         <= sof_d;
    end
  end

  // program storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (prog_we) prog[count_q[AW-1:0]] <= load_data;
  end

  assign eng_instr   = eng_instr_q;
  assign pass        = pass_q;
  assign fail_valid  = fail_valid_q;
  assign fail_idx    = fail_idx_q;
  assign timeout_err = timeout_err_q;
  assign count       = count_q;

endmodule

// File: tb/tb_pmbist_seq_ctrl.sv
// tb_pmbist_seq_ctrl: self-checking bench for the BIST program sequencer.
// Table-driven load/clear vectors, directed runs and randomized runs vs a model.
module tb_pmbist_seq_ctrl;

  localparam int IW    = 32;
  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_ready;
  logic          clear;
  logic          run;
  logic          abort;
  logic          stop_on_fail;
  logic [IW-1:0] eng_instr;
  logic          eng_start;
  logic          eng_done;
  logic          eng_fail;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail_valid;
  logic [2:0]    fail_idx;
  logic          timeout_err;
  logic [3:0]    count;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pmbist_seq_ctrl #(
    .IW(IW),
    .DEPTH(DEPTH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_ready(load_ready),
    .clear(clear),
    .run(run),
    .abort(abort),
    .stop_on_fail(stop_on_fail),
    .eng_instr(eng_instr),
    .eng_start(eng_start),
    .eng_done(eng_done),
    .eng_fail(eng_fail),
    .busy(busy),
    .done(done),
    .pass(pass),
    .fail_valid(fail_valid),
    .fail_idx(fail_idx),
    .timeout_err(timeout_err),
    .count(count)
  );

  // model of the stored program and engine behaviour per element
  logic [IW-1:0] prog_m [DEPTH];
  int            cnt_m;
  int            lat_a  [DEPTH];
  bit            fail_a [DEPTH];

  typedef struct {
    bit            lv;
    bit            clr;
    logic [IW-1:0] data;
    int            exp_cnt;
    bit            exp_rdy;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    cnt_m = 0;
  endtask

  task automatic load_word(input logic [IW-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    step();
    load_valid = 1'b0;
    if (cnt_m < DEPTH) begin
      prog_m[cnt_m] = d;
      cnt_m++;
    end
  endtask

  task automatic set_eng(input int lat, input bit f);
    for (int i = 0; i < DEPTH; i++) begin
      lat_a[i]  = lat;
      fail_a[i] = f;
    end
  endtask

  // Runs the program; the engine answers element i lat_a[i] cycles after
  // its start. abort_el: abort raised together with that element's done.
  // no_ans: that element never gets a done.
  task automatic run_prog(input bit stop, input int abort_el,
                          input int no_ans, input string tag);
    logic [IW-1:0] exp_q [$];
    logic [IW-1:0] got_q [$];
    bit  e_pass, e_fv, e_to, got_done;
    int  e_fi, e_t, t, cur, nst, due;
    e_pass = 1'b1;
    e_fv   = 1'b0;
    e_to   = 1'b0;
    e_fi   = 0;
    e_t    = 1;
    for (int i = 0; i < cnt_m; i++) begin
      exp_q.push_back(prog_m[i]);
      if (i == no_ans) begin
        e_to   = 1'b1;
        e_pass = 1'b0;
        if (!e_fv) begin e_fv = 1'b1; e_fi = i; end
        e_t += TO;
        break;
      end
      e_t += lat_a[i] + 1;
      if (i == abort_el) begin e_pass = 1'b0; break; end
      if (fail_a[i]) begin
        e_pass = 1'b0;
        if (!e_fv) begin e_fv = 1'b1; e_fi = i; end
        if (stop) break;
      end
    end

    run          = 1'b1;
    stop_on_fail = stop;
    step();
    run          = 1'b0;
    stop_on_fail = 1'b0;
    chk({tag, ":busy_t1"}, busy, cnt_m > 0);
    t        = 1;
    nst      = 0;
    cur      = 0;
    due      = -1;
    got_done = 1'b0;
    while (t <= 400) begin
      if (eng_start) begin
        got_q.push_back(eng_instr);
        cur = nst;
        nst++;
        if (cur >= DEPTH || cur == no_ans) due = -1;
        else due = t + lat_a[cur];
      end
      if (done) begin got_done = 1'b1; break; end
      eng_done = (t == due);
      eng_fail = (t == due) && fail_a[cur];
      abort    = (t == due) && (cur == abort_el);
      step();
      t++;
    end
    eng_done = 1'b0;
    eng_fail = 1'b0;
    abort    = 1'b0;
    chk({tag, ":done_seen"}, got_done, 1'b1);
    chk({tag, ":done_cycle"}, t, e_t);
    chk({tag, ":busy_fin"}, busy, 1'b0);
    chk({tag, ":pass"}, pass, e_pass);
    chk({tag, ":fail_valid"}, fail_valid, e_fv);
    if (e_fv) chk({tag, ":fail_idx"}, fail_idx, e_fi);
    chk({tag, ":timeout_err"}, timeout_err, e_to);
    chk({tag, ":count"}, count, cnt_m);
    chk({tag, ":n_starts"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, ":instr"}, got_q[i], exp_q[i]);
    step();
    chk({tag, ":done_pulse"}, done, 1'b0);
    chk({tag, ":pass_hold"}, pass, e_pass);
  endtask

  initial begin
    rst          = 1'b1;
    load_valid   = 1'b0;
    load_data    = '0;
    clear        = 1'b0;
    run          = 1'b0;
    abort        = 1'b0;
    stop_on_fail = 1'b0;
    eng_done     = 1'b0;
    eng_fail     = 1'b0;
    cnt_m        = 0;

    vt[0]  = '{1'b0, 1'b1, 32'h0,  0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 32'h10, 1, 1'b1};
    vt[2]  = '{1'b1, 1'b0, 32'h11, 2, 1'b1};
    vt[3]  = '{1'b1, 1'b0, 32'h12, 3, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 32'h13, 4, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 32'h14, 5, 1'b1};
    vt[6]  = '{1'b1, 1'b0, 32'h15, 6, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 32'h16, 7, 1'b1};
    vt[8]  = '{1'b1, 1'b0, 32'h17, 8, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 32'h99, 8, 1'b0};
    vt[10] = '{1'b1, 1'b1, 32'h55, 0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 32'h66, 1, 1'b1};

    step();
    step();
    chk("rst:count", count, 0);
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:pass", pass, 1'b0);
    chk("rst:fail_valid", fail_valid, 1'b0);
    chk("rst:fail_idx", fail_idx, 0);
    chk("rst:timeout_err", timeout_err, 1'b0);
    chk("rst:eng_start", eng_start, 1'b0);
    chk("rst:eng_instr", eng_instr, 0);
    chk("rst:load_ready", load_ready, 1'b1);
    rst = 1'b0;
    step();

    // three-word program, all pass, then failure variants
    do_clear();
    load_word(32'hA1);
    load_word(32'hB2);
    load_word(32'hC3);
    set_eng(4, 1'b0);
    run_prog(1'b0, -1, -1, "pass3");
    fail_a[1] = 1'b1;
    run_prog(1'b0, -1, -1, "fail1_nostop");
    run_prog(1'b1, -1, -1, "fail1_stop");

    // longest accepted latency, then no answer at all
    set_eng(4, 1'b0);
    lat_a[0] = TO - 1;
    run_prog(1'b0, -1, -1, "lat_max");
    set_eng(4, 1'b0);
    run_prog(1'b0, -1, 0, "timeout");

    // abort together with element 1's done
    run_prog(1'b0, 1, -1, "abort");

    // load/clear table
    for (int i = 0; i < 12; i++) begin
      load_valid = vt[i].lv;
      clear      = vt[i].clr;
      load_data  = vt[i].data;
      step();
      if (vt[i].clr) cnt_m = 0;
      else if (vt[i].lv && cnt_m < DEPTH) begin
        prog_m[cnt_m] = vt[i].data;
        cnt_m++;
      end
      chk($sformatf("tbl%0d:count", i), count, vt[i].exp_cnt);
      chk($sformatf("tbl%0d:ready", i), load_ready, vt[i].exp_rdy);
    end
    load_valid = 1'b0;
    clear      = 1'b0;

    // empty program
    do_clear();
    run_prog(1'b0, -1, -1, "empty");

    // randomized programs and engine behaviour
    for (int r = 0; r < 25; r++) begin
      int n, ab, na;
      bit st;
      do_clear();
      n = $urandom_range(0, DEPTH);
      for (int i = 0; i < n; i++) load_word($urandom);
      for (int i = 0; i < DEPTH; i++) begin
        lat_a[i]  = $urandom_range(1, TO - 1);
        fail_a[i] = ($urandom_range(0, 3) == 0);
      end
      st = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, DEPTH - 1) : -1;
      na = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DEPTH - 1) : -1;
      run_prog(st, ab, na, $sformatf("rnd%0d", r));
    end

    // reset in the middle of a run
    do_clear();
    load_word(32'h1);
    load_word(32'h2);
    load_word(32'h3);
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    chk("midrst:busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst:busy", busy, 1'b0);
    chk("midrst:count", count, 0);
    chk("midrst:eng_start", eng_start, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pmbist_seq_ctrl.md
Name: pmbist_seq_ctrl

Overview:
- Program sequencer for the programmable memory BIST engine.
- Holds a small program of BIST instruction words loaded one per cycle from the tester side.
- On run, issues each word in order to the engine with a start pulse, waits for the engine's done/fail handshake, and accumulates an overall pass/fail plus the index of the first failing element.
- Sits between the scan/tester interface and the existing BIST engine, replacing manual per-instruction scan + ts sequencing.

Parameters:
IW, 32, instruction word width (set to `SCAN_WIDTH at instantiation)
DEPTH, 8, program slots; power of two, >=2
TIMEOUT, 4096, max cycles to wait for eng_done per element; >=2

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-high reset
load_valid  in  1  program word available
load_data  in  IW  program word
load_ready  out  1  = (state==IDLE) && (count<DEPTH)
clear  in  1  empty program (IDLE only)
run  in  1  start executing program (IDLE only)
abort  in  1  terminate a running program
stop_on_fail  in  1  end run at first failing element; sampled at run
eng_instr  out  IW  instruction to BIST engine
eng_start  out  1  one-cycle start pulse to engine
eng_done  in  1  engine finished current element (1-cycle pulse)
eng_fail  in  1  engine result; valid only with eng_done
busy  out  1  program executing
done  out  1  one-cycle pulse, run complete
pass  out  1  all executed elements passed
fail_valid  out  1  fail_idx holds a recorded failure
fail_idx  out  $clog2(DEPTH)  index of first failing or timed-out element
timeout_err  out  1  an element exceeded TIMEOUT
count  out  $clog2(DEPTH+1)  number of loaded words

Behaviour:
- Reset:
  - state=IDLE; count, idx, timer = 0.
  - Outputs eng_instr, eng_start, busy, done, pass, fail_valid, fail_idx, timeout_err = 0.
  - Program storage is not reset.
- States: IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - Load: load_valid && load_ready writes prog[count] and increments count.
  - clear=1 sets count=0; clear takes priority over a same-cycle load, and the word is dropped.
  - run=1 with count==0 goes to FINISH with pass=1.
  - run=1 with count>0: idx=0; pass=1; fail_valid=0; timeout_err=0; latch stop_on_fail; go to ISSUE.
  - Priority in IDLE: clear > run > load.
  - The program persists after a run and can be re-run without reloading.
- ISSUE (one cycle):
  - eng_start=1 (Moore output); eng_instr=prog[idx], registered on entry; timer=0; next state WAIT.
  - eng_done is ignored in ISSUE.
- WAIT:
  - timer increments each cycle.
  - On eng_done with eng_fail=1: pass<=0; if !fail_valid, set fail_idx<=idx and fail_valid<=1.
  - On eng_done: go to FINISH if (eng_fail && latched stop_on_fail) or idx==count-1; otherwise idx++ and go to ISSUE.
  - If timer==TIMEOUT-1 without eng_done: timeout_err<=1, pass<=0, record fail_idx if not yet valid, go to FINISH.
- FINISH (one cycle): done=1, busy=0, then IDLE. pass, fail_valid, fail_idx and timeout_err hold until the next run or rst.
- busy=1 in ISSUE and WAIT only.
- eng_instr holds its last value after a run.
- abort in ISSUE or WAIT: go to FINISH next cycle with pass<=0. abort wins over a same-cycle eng_done, and that result is discarded.
- Ignored inputs:
  - run, clear and load are ignored outside IDLE, and load_ready=0 there.
  - abort is ignored in IDLE and FINISH.
- Latency:
  - run sampled at edge k gives eng_start high during cycle k+1.
  - eng_done sampled at edge m gives the next eng_start during cycle m+1.
  - eng_done of the last element at edge m gives done during cycle m+1.
- rst mid-run: returns to IDLE immediately with count=0; the engine is not notified.

Test Plan:
- Load 3 words (0xA1, 0xB2, 0xC3) then run; engine returns done/fail=0 four cycles after each start -> eng_start pulses with eng_instr 0xA1, 0xB2, 0xC3 in order; done pulses once; pass=1; fail_valid=0; count stays 3.
- Same program, eng_fail=1 on element 1, stop_on_fail=0 -> all 3 elements issued; pass=0; fail_idx=1; fail_valid=1. Repeat with stop_on_fail=1 -> only 2 starts; done pulses one cycle after element 1's eng_done.
- Load 8 words -> load_ready drops after the 8th; a 9th load_valid is not accepted and count=8. Then clear and load in the same cycle -> count=0.
- run with count=0 -> done pulses in the next cycle, pass=1, and eng_start never asserts.
- With TIMEOUT=16, the engine never answers element 0 -> done occurs 16 cycles after eng_start; timeout_err=1; pass=0; fail_idx=0.
- abort together with eng_done during element 1 -> element 2 is not issued; pass=0; fail_valid=0. Then rst mid-run -> busy=0 and count=0 next cycle.
